// File: rtl/game_session_sched.sv
// Arcade credit pool shared by N_PLAYER stations.
// Round-robin session grant with per-cycle burn and time slicing.
module game_session_sched #(
  parameter int N_PLAYER   = 4,
  parameter int CREDIT_W   = 10,
  parameter int WARN_LVL   = 10,
  parameter int BOOST_COST = 2,
  parameter int QUANTUM    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CREDIT_W-1:0] money,
  input  logic                set,
  input  logic [N_PLAYER-1:0] req,
  input  logic [N_PLAYER-1:0] boost,
  output logic [N_PLAYER-1:0] grant,
  output logic [CREDIT_W-1:0] remain,
  output logic                yellow,
  output logic                red,
  output logic                session_done
);

  localparam int OW = $clog2(N_PLAYER);
  localparam int TW = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t              state, nxt;
  logic [OW-1:0]       owner, rr_ptr, win, cand;
  logic [TW-1:0]       tick;
  logic                found, start, own_req, others, sess_end;
  logic [N_PLAYER-1:0] own_vec;
  logic [CREDIT_W:0]   sum;
  logic [CREDIT_W-1:0] cost, hi, rem_nxt;

  assign own_vec = {{(N_PLAYER-1){1'b0}}, 1'b1} << owner;
  assign own_req = req[owner];
  assign others  = |(req & ~own_vec);

  // first requester at or after the rr pointer, wrapping
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 0; i < N_PLAYER; i++) begin
      cand = OW'((int'(rr_ptr) + i) % N_PLAYER);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign start = found && (remain != '0);

  always_comb begin
    cost = '0;
    if (state == PLAY && own_req)
      cost = boost[owner] ? CREDIT_W'(BOOST_COST) : CREDIT_W'(1);
  end

  // coin is added (saturating) before the burn is taken off
  assign sum     = {1'b0, remain} + (set ? {1'b0, money} : '0);
  assign hi      = sum[CREDIT_W] ? '1 : sum[CREDIT_W-1:0];
  assign rem_nxt = (hi < cost) ? '0 : hi - cost;

  assign sess_end = !own_req || (rem_nxt == '0) ||
                    ((tick == TW'(QUANTUM-1)) && others);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start) nxt = PLAY;
      PLAY:    if (sess_end) nxt = GAP;
      GAP:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    grant        = (state == PLAY) ? own_vec : '0;
    session_done = (state == GAP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remain <= '0;
      yellow <= 1'b0;
      red    <= 1'b0;
      owner  <= '0;
      rr_ptr <= '0;
      tick   <= '0;
    end else begin
      remain <= rem_nxt;
      red    <= (rem_nxt == '0);
      yellow <= (rem_nxt != '0) &&
                (rem_nxt <= CREDIT_W'(WARN_LVL));
      if (state == IDLE && start) begin
        owner <= win;
        tick  <= '0;
      end
      if (state == PLAY) begin
        // saturate so a late waiter ends an overlong session at once
        if (tick != TW'(QUANTUM-1))
          tick <= tick + TW'(1);
        if (sess_end)
          rr_ptr <= (owner == OW'(N_PLAYER-1)) ? '0 : owner + OW'(1);
      end
    end
  end

endmodule
